// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard controller: forwarding mux codes
// and controller state.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_ALU_M = 2'b01,
    FWD_WB_W  = 2'b10,
    FWD_LD_M  = 2'b11
  } fwd_e_t;

  typedef enum logic [1:0] {
    FWDD_RF    = 2'b00,
    FWDD_ALU_E = 2'b01,
    FWDD_ALU_M = 2'b10
  } fwd_d_t;

  typedef enum logic {
    IDLE    = 1'b0,
    MC_BUSY = 1'b1
  } hz_state_e;

endpackage

// File: rtl/hazard_src_match.sv
// Per-source-operand hazard detection: E-stage forward code, D-stage bypass
// code and load-use hit against the load currently in E.
module hazard_src_match
  import hazard_pkg::*;
#(
  parameter int AW = 5
) (
  input  logic [AW-1:0] srcE,
  input  logic [AW-1:0] srcD,
  input  logic [AW-1:0] rdAddrE,
  input  logic [AW-1:0] rdAddrM,
  input  logic [AW-1:0] rdAddrW,
  input  logic          rdWrenE,
  input  logic          rdWrenM,
  input  logic          rdWrenW,
  input  logic          wbSelM,
  input  logic          ldE,
  output logic [1:0]    fwdE,
  output logic [1:0]    fwdD,
  output logic          luHit
);

  // x0 never forwards; the younger producer (M over W, E over M) wins.
  always_comb begin
    fwdE = FWD_RF;
    if (srcE != '0) begin
      if (rdWrenM && (rdAddrM == srcE))
        fwdE = wbSelM ? FWD_LD_M : FWD_ALU_M;
      else if (rdWrenW && (rdAddrW == srcE))
        fwdE = FWD_WB_W;
    end
  end

  always_comb begin
    fwdD = FWDD_RF;
    if (srcD != '0) begin
      if (rdWrenE && (rdAddrE == srcD))
        fwdD = FWDD_ALU_E;
      else if (rdWrenM && (rdAddrM == srcD))
        fwdD = FWDD_ALU_M;
    end
  end

  assign luHit = ldE & rdWrenE & (rdAddrE != '0) & (srcD == rdAddrE);

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Hazard controller for the 5-stage core: forwarding, load-use stall, branch
// flush and multi-cycle execute freeze, plus a saturating stall-cycle counter.
//
//   state   | meaning
//   IDLE    | normal flow; load-use / branch / multi-cycle start decoded
//   MC_BUSY | multi-cycle op in E; F/D/E frozen until mc_done
module hazard_ctrl_unit
  import hazard_pkg::*;
#(
  parameter int AW    = 5,
  parameter int NSRC  = 2,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 br_selE,
  input  logic                 ldE,
  input  logic                 wb_selM,
  input  logic                 rd_wrenE,
  input  logic                 rd_wrenM,
  input  logic                 rd_wrenW,
  input  logic [AW-1:0]        rd_addrE,
  input  logic [AW-1:0]        rd_addrM,
  input  logic [AW-1:0]        rd_addrW,
  input  logic [NSRC*AW-1:0]   rs_addrD,
  input  logic [NSRC*AW-1:0]   rs_addrE,
  input  logic                 mc_reqE,
  input  logic                 mc_done,
  output logic [NSRC*2-1:0]    fwdE_sel,
  output logic [NSRC*2-1:0]    fwdD_sel,
  output logic                 stallF,
  output logic                 stallD,
  output logic                 stallE,
  output logic                 flushD,
  output logic                 flushE,
  output logic                 mc_start,
  output logic [CNT_W-1:0]     stall_cnt
);

  hz_state_e         state, stateNext;
  logic [NSRC*2-1:0] fwdEC, fwdDC;
  logic [NSRC-1:0]   luHits;
  logic              luAny;
  logic              stallFC, stallDC, stallEC, flushDC, flushEC, mcStartC;
  logic [CNT_W-1:0]  stallCnt;

  for (genvar i = 0; i < NSRC; i++) begin : g_src
    hazard_src_match #(.AW(AW)) u_match (
      .srcE    (rs_addrE[i*AW +: AW]),
      .srcD    (rs_addrD[i*AW +: AW]),
      .rdAddrE (rd_addrE),
      .rdAddrM (rd_addrM),
      .rdAddrW (rd_addrW),
      .rdWrenE (rd_wrenE),
      .rdWrenM (rd_wrenM),
      .rdWrenW (rd_wrenW),
      .wbSelM  (wb_selM),
      .ldE     (ldE),
      .fwdE    (fwdEC[i*2 +: 2]),
      .fwdD    (fwdDC[i*2 +: 2]),
      .luHit   (luHits[i])
    );
  end

  assign luAny = |luHits;

  // Priority in IDLE: branch flush, then multi-cycle start, then load-use.
  always_comb begin
    stateNext = state;
    stallFC   = 1'b0;
    stallDC   = 1'b0;
    stallEC   = 1'b0;
    flushDC   = 1'b0;
    flushEC   = 1'b0;
    mcStartC  = 1'b0;
    case (state)
      IDLE: begin
        if (br_selE) begin
          flushDC = 1'b1;
          flushEC = 1'b1;
        end else if (mc_reqE) begin
          mcStartC  = 1'b1;
          stallFC   = 1'b1;
          stallDC   = 1'b1;
          stallEC   = 1'b1;
          stateNext = MC_BUSY;
        end else if (luAny) begin
          stallFC = 1'b1;
          stallDC = 1'b1;
          flushEC = 1'b1;
        end
      end
      MC_BUSY: begin
        if (mc_done) begin
          stateNext = IDLE;
        end else begin
          stallFC = 1'b1;
          stallDC = 1'b1;
          stallEC = 1'b1;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      stallCnt <= '0;
    end else begin
      state <= stateNext;
      if (stallFC && (stallCnt != {CNT_W{1'b1}}))
        stallCnt <= stallCnt + 1'b1;
    end
  end

  // Everything is forced quiet while reset is held, including the
  // purely combinational forwarding selects.
  assign fwdE_sel  = rst_n ? fwdEC : '0;
  assign fwdD_sel  = rst_n ? fwdDC : '0;
  assign stallF    = rst_n & stallFC;
  assign stallD    = rst_n & stallDC;
  assign stallE    = rst_n & stallEC;
  assign flushD    = rst_n & flushDC;
  assign flushE    = rst_n & flushEC;
  assign mc_start  = rst_n & mcStartC;
  assign stall_cnt = stallCnt;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Self-checking bench for hazard_ctrl_unit: directed scenarios plus a
// randomized run against a behavioural model of the hazard rules.
module tb_hazard_ctrl_unit;
  localparam int AW = 5, NSRC = 2, CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rstN, br, ld, wbSel, wrE, wrM, wrW, mcReq, mcDone;
  logic [AW-1:0] rdE, rdM, rdW;
  logic [NSRC*AW-1:0] rsD, rsE;
  logic [NSRC*2-1:0] fwdE_sel, fwdD_sel;
  logic stallF, stallD, stallE, flushD, flushE, mc_start;
  logic [CW-1:0] stall_cnt;
  logic [13:0] obs;

  int nTests = 0, nFail = 0;
  bit mBusy = 0;
  int mCnt = 0;

  always #5 clk = ~clk;

  hazard_ctrl_unit #(.AW(AW), .NSRC(NSRC), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rstN), .br_selE(br), .ldE(ld), .wb_selM(wbSel),
    .rd_wrenE(wrE), .rd_wrenM(wrM), .rd_wrenW(wrW),
    .rd_addrE(rdE), .rd_addrM(rdM), .rd_addrW(rdW),
    .rs_addrD(rsD), .rs_addrE(rsE), .mc_reqE(mcReq), .mc_done(mcDone),
    .fwdE_sel(fwdE_sel), .fwdD_sel(fwdD_sel), .stallF(stallF), .stallD(stallD),
    .stallE(stallE), .flushD(flushD), .flushE(flushE), .mc_start(mc_start),
    .stall_cnt(stall_cnt)
  );

  assign obs = {fwdE_sel, fwdD_sel, stallF, stallD, stallE, flushD, flushE, mc_start};

  // Expected outputs from the hazard rules, same packing as obs.
  function automatic logic [13:0] modelOut();
    logic [3:0] fe, fd;
    logic [4:0] ctl;   // stallF stallD stallE flushD flushE
    logic st;
    bit lu;
    fe = '0; fd = '0; ctl = '0; st = 0; lu = 0;
    if (!rstN) return '0;
    for (int i = 0; i < NSRC; i++) begin
      int s, d;
      s = int'(rsE[i*AW +: AW]);
      d = int'(rsD[i*AW +: AW]);
      if (s != 0 && wrM && int'(rdM) == s) fe[i*2 +: 2] = wbSel ? 2'd3 : 2'd1;
      else if (s != 0 && wrW && int'(rdW) == s) fe[i*2 +: 2] = 2'd2;
      if (d != 0 && wrE && int'(rdE) == d) fd[i*2 +: 2] = 2'd1;
      else if (d != 0 && wrM && int'(rdM) == d) fd[i*2 +: 2] = 2'd2;
      if (ld && wrE && rdE != 0 && int'(rdE) == d) lu = 1;
    end
    if (mBusy) ctl = mcDone ? 5'b00000 : 5'b11100;
    else if (br) ctl = 5'b00011;
    else if (mcReq) begin ctl = 5'b11100; st = 1; end
    else if (lu) ctl = 5'b11001;
    return {fe, fd, ctl, st};
  endfunction

  task automatic advance();
    logic [13:0] e;
    e = modelOut();
    @(posedge clk); #1;
    if (rstN) begin
      if (e[5] && mCnt < CMAX) mCnt++;
      if (!mBusy && !br && mcReq) mBusy = 1;
      else if (mBusy && mcDone) mBusy = 0;
    end
  endtask

  task automatic clearIn();
    {br, ld, wbSel, wrE, wrM, wrW, mcReq, mcDone} = '0;
    rdE = '0; rdM = '0; rdW = '0; rsD = '0; rsE = '0;
  endtask

  task automatic resetPulse();
    clearIn();
    rstN = 1'b0; mBusy = 0; mCnt = 0;
    #2 rstN = 1'b1;
    advance();
  endtask

  task automatic test_reset();
    clearIn();
    rstN = 1'b0;
    mcReq = 1'b1; wrM = 1'b1; rdM = 5'd3; rsE = {5'd3, 5'd3}; rsD = {5'd3, 5'd3};
    #1;
    nTests++; if (obs !== '0) begin nFail++; $display("FAIL reset_outputs got=%h want=0", obs); end
    nTests++; if (stall_cnt !== '0) begin nFail++; $display("FAIL reset_cnt got=%0d want=0", stall_cnt); end
    advance(); advance();
    nTests++; if (mc_start !== 1'b0) begin nFail++; $display("FAIL reset_held_start got=%b want=0", mc_start); end
    clearIn(); rstN = 1'b1;
    advance();
  endtask

  task automatic test_forward();
    clearIn();
    rsE[4:0] = 5'd3; rdM = 5'd3; wrM = 1'b1; rdW = 5'd3; wrW = 1'b1;
    #3;
    nTests++; if (fwdE_sel[1:0] !== 2'b01) begin nFail++; $display("FAIL fwdE_m_beats_w got=%b want=01", fwdE_sel[1:0]); end
    wbSel = 1'b1; #1;
    nTests++; if (fwdE_sel[1:0] !== 2'b11) begin nFail++; $display("FAIL fwdE_load got=%b want=11", fwdE_sel[1:0]); end
    wrM = 1'b0; #1;
    nTests++; if (fwdE_sel[1:0] !== 2'b10) begin nFail++; $display("FAIL fwdE_wb got=%b want=10", fwdE_sel[1:0]); end
    advance();
    clearIn();
    rsE[9:5] = 5'd0; rsD[9:5] = 5'd0; rdM = 5'd0; wrM = 1'b1; rdE = 5'd0; wrE = 1'b1;
    #3;
    nTests++; if (fwdE_sel[3:2] !== 2'b00) begin nFail++; $display("FAIL fwdE_x0 got=%b want=00", fwdE_sel[3:2]); end
    nTests++; if (fwdD_sel[3:2] !== 2'b00) begin nFail++; $display("FAIL fwdD_x0 got=%b want=00", fwdD_sel[3:2]); end
    rsD[9:5] = 5'd7; rdE = 5'd7; rdM = 5'd7; #1;
    nTests++; if (fwdD_sel[3:2] !== 2'b01) begin nFail++; $display("FAIL fwdD_e_beats_m got=%b want=01", fwdD_sel[3:2]); end
    wrE = 1'b0; #1;
    nTests++; if (fwdD_sel[3:2] !== 2'b10) begin nFail++; $display("FAIL fwdD_m got=%b want=10", fwdD_sel[3:2]); end
    advance();
  endtask

  task automatic test_load_use();
    clearIn();
    ld = 1'b1; rdE = 5'd5; wrE = 1'b1; rsD[9:5] = 5'd5;
    #3;
    nTests++; if ({stallF, stallD, stallE, flushD, flushE} !== 5'b11001) begin
      nFail++; $display("FAIL load_use got=%b want=11001", {stallF, stallD, stallE, flushD, flushE}); end
    br = 1'b1; #1;
    nTests++; if ({stallF, stallD, flushD, flushE} !== 4'b0011) begin
      nFail++; $display("FAIL branch_over_lu got=%b want=0011", {stallF, stallD, flushD, flushE}); end
    advance();
    clearIn(); #3;
    nTests++; if (obs !== modelOut()) begin nFail++; $display("FAIL lu_one_cycle got=%h want=%h", obs, modelOut()); end
    advance();
  endtask

  task automatic test_mc_op();
    int c0;
    resetPulse();
    c0 = int'(stall_cnt);
    clearIn(); mcReq = 1'b1; #3;
    nTests++; if ({mc_start, stallF, stallD, stallE} !== 4'b1111) begin
      nFail++; $display("FAIL mc_start got=%b want=1111", {mc_start, stallF, stallD, stallE}); end
    advance();
    for (int k = 1; k <= 4; k++) begin
      br = (k == 2); #3;
      nTests++; if (obs !== modelOut() || {mc_start, stallF, flushD} !== 3'b010) begin
        nFail++; $display("FAIL mc_busy cyc=%0d got=%h want=%h", k, obs, modelOut()); end
      advance();
    end
    br = 1'b0; mcDone = 1'b1; #3;
    nTests++; if ({stallF, stallD, stallE} !== 3'b000) begin
      nFail++; $display("FAIL mc_done_drop got=%b want=000", {stallF, stallD, stallE}); end
    advance();
    clearIn(); #3;
    nTests++; if (int'(stall_cnt) - c0 !== 5) begin
      nFail++; $display("FAIL mc_cnt_delta got=%0d want=5", int'(stall_cnt) - c0); end
    nTests++; if (obs !== '0) begin nFail++; $display("FAIL mc_back_idle got=%h want=0", obs); end
    advance();
  endtask

  task automatic test_reset_mid();
    clearIn(); mcReq = 1'b1; advance(); advance(); advance();
    rstN = 1'b0; mBusy = 0; mCnt = 0; #1;
    nTests++; if (obs !== '0 || stall_cnt !== '0) begin
      nFail++; $display("FAIL reset_mid got=%h cnt=%0d want=0 cnt=0", obs, stall_cnt); end
    advance();
    clearIn(); mcDone = 1'b1; rstN = 1'b1; #3;
    nTests++; if ({mc_start, stallF, stallE} !== 3'b000) begin
      nFail++; $display("FAIL post_reset_idle got=%b want=000", {mc_start, stallF, stallE}); end
    advance();
    mcDone = 1'b0; #3;
    nTests++; if (stall_cnt !== '0 || obs !== '0) begin
      nFail++; $display("FAIL late_done_ignored got=%h cnt=%0d want=0 cnt=0", obs, stall_cnt); end
    advance();
  endtask

  task automatic test_saturate();
    clearIn(); mcReq = 1'b1; advance();
    for (int k = 0; k < 20; k++) advance();
    #3;
    nTests++; if (stall_cnt !== 4'(CMAX)) begin nFail++; $display("FAIL cnt_saturate got=%0d want=%0d", stall_cnt, CMAX); end
    nTests++; if (stallF !== 1'b1) begin nFail++; $display("FAIL sat_still_busy got=%b want=1", stallF); end
    mcDone = 1'b1; advance();
    clearIn(); advance();
  endtask

  task automatic test_back_to_back();
    resetPulse();
    clearIn(); mcReq = 1'b1; advance(); advance();
    mcDone = 1'b1; #3;
    nTests++; if (stallE !== 1'b0) begin nFail++; $display("FAIL b2b_done got=%b want=0", stallE); end
    advance();
    mcDone = 1'b0; #3;
    nTests++; if ({mc_start, stallE} !== 2'b11) begin
      nFail++; $display("FAIL b2b_restart got=%b want=11", {mc_start, stallE}); end
    advance();
    mcDone = 1'b1; advance();
    clearIn(); #3;
    nTests++; if (stall_cnt !== 4'(mCnt)) begin nFail++; $display("FAIL b2b_cnt got=%0d want=%0d", stall_cnt, mCnt); end
    advance();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      br = ($urandom_range(0, 7) == 0); ld = $urandom_range(0, 1);
      wbSel = $urandom_range(0, 1);
      wrE = $urandom_range(0, 1); wrM = $urandom_range(0, 1); wrW = $urandom_range(0, 1);
      rdE = 5'($urandom_range(0, 3)); rdM = 5'($urandom_range(0, 3)); rdW = 5'($urandom_range(0, 3));
      rsD = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      rsE = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      mcReq = ($urandom_range(0, 9) == 0); mcDone = ($urandom_range(0, 3) == 0);
      #3;
      nTests++; if (obs !== modelOut()) begin
        nFail++; $display("FAIL random n=%0d got=%h want=%h", n, obs, modelOut()); end
      if (n % 16 == 0) begin
        nTests++; if (stall_cnt !== 4'(mCnt)) begin
          nFail++; $display("FAIL random_cnt n=%0d got=%0d want=%0d", n, stall_cnt, mCnt); end
      end
      advance();
      if (n == 200) resetPulse();
    end
    clearIn(); mcDone = 1'b1; advance();
  endtask

  initial begin
    test_reset();
    test_forward();
    test_load_use();
    test_mc_op();
    test_reset_mid();
    test_saturate();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
